// File: rtl/ubio_mem_pkg.sv
// Shared types and constants for the uBio memory responder.
// Holds the responder FSM state type and the bus width / direction encodings.
package ubio_mem_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    localparam logic RD = 1'b1;
    localparam logic WR = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/ubio_mem_array.sv
// Word storage for the uBio memory responder.
// Single port: synchronous write, combinational read, contents not reset.
module ubio_mem_array
    import ubio_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/ubio_mem_responder.sv
// Multi-cycle word memory responder for the uBio CPU bus with programmable wait states.
// Optional write protection of the low program region: define UBIO_MEM_WRITE_PROTECT_EN.
module ubio_mem_responder
    import ubio_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1,
    parameter int RO_WORDS    = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              r_nw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              err,
    output logic              busy
);

    localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH_U   = 32'(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    // Handshake: the requester raises req with r_nw/addr/wdata and holds them until
    // the one-cycle ready strobe; a request is taken only in IDLE, never in RESP.
    state_t              state;
    logic [3:0]          wcnt;
    logic                r_nw_q;
    logic [ADDR_W-2:0]   idx_q;
    logic [DATA_W-1:0]   wdata_q;

    logic                cur_r_nw;
    logic [ADDR_W-2:0]   cur_idx;
    logic                cur_in_range;
    logic                cur_prot;
    logic                we;
    logic [DATA_W-1:0]   arr_rdata;
    logic                unused_addr0;

    // In IDLE the live request is the one being accepted; afterwards the latched copy.
    assign cur_r_nw     = (state == IDLE) ? r_nw : r_nw_q;
    assign cur_idx      = (state == IDLE) ? addr[ADDR_W-1:1] : idx_q;
    assign cur_in_range = ({17'd0, cur_idx} < DEPTH_U);
    assign unused_addr0 = addr[0];

`ifdef UBIO_MEM_WRITE_PROTECT_EN
    localparam logic [31:0] RO_U = 32'(RO_WORDS);
    assign cur_prot = (cur_r_nw == WR) && ({17'd0, cur_idx} < RO_U);
`else
    logic unused_ro;
    assign unused_ro = (RO_WORDS > 0);
    assign cur_prot  = 1'b0;
`endif

    assign we = (state == RESP) && (r_nw_q == WR) && cur_in_range && !cur_prot;

    ubio_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .idx   (cur_idx[IDX_W-1:0]),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            wcnt    <= 4'd0;
            r_nw_q  <= RD;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata   <= '0;
            ready   <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready <= 1'b0;
                    err   <= 1'b0;
                    if (req) begin
                        r_nw_q  <= r_nw;
                        idx_q   <= addr[ADDR_W-1:1];
                        wdata_q <= wdata;
                        busy    <= 1'b1;
                        if (WAIT_STATES == 0) begin
                            state <= RESP;
                            ready <= 1'b1;
                            err   <= !cur_in_range || cur_prot;
                            if (cur_r_nw == RD) begin
                                rdata <= cur_in_range ? arr_rdata : '0;
                            end
                        end else begin
                            wcnt  <= WAIT_LOAD;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (wcnt == 4'd0) begin
                        state <= RESP;
                        ready <= 1'b1;
                        err   <= !cur_in_range || cur_prot;
                        if (cur_r_nw == RD) begin
                            rdata <= cur_in_range ? arr_rdata : '0;
                        end
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    ready <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ubio_mem_responder.sv
// Directed bench for ubio_mem_responder: three instances with 1, 0 and 3 wait states.
// Expected values are hand-derived; protect-region expectations follow UBIO_MEM_WRITE_PROTECT_EN.
module tb_ubio_mem_responder;

    logic        clk;
    logic        rst;
    logic [2:0]  req_v;
    logic        r_nw;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata_a [3];
    logic        ready_a [3];
    logic        err_a   [3];
    logic        busy_a  [3];

    int checks;
    int passed;
    int cyc;
    int ws_of [3];

    ubio_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(1), .RO_WORDS(64)) u_ws1 (
        .clk(clk), .rst(rst), .req(req_v[0]), .r_nw(r_nw), .addr(addr), .wdata(wdata),
        .rdata(rdata_a[0]), .ready(ready_a[0]), .err(err_a[0]), .busy(busy_a[0])
    );

    ubio_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0), .RO_WORDS(64)) u_ws0 (
        .clk(clk), .rst(rst), .req(req_v[1]), .r_nw(r_nw), .addr(addr), .wdata(wdata),
        .rdata(rdata_a[1]), .ready(ready_a[1]), .err(err_a[1]), .busy(busy_a[1])
    );

    ubio_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(3), .RO_WORDS(64)) u_ws3 (
        .clk(clk), .rst(rst), .req(req_v[2]), .r_nw(r_nw), .addr(addr), .wdata(wdata),
        .rdata(rdata_a[2]), .ready(ready_a[2]), .err(err_a[2]), .busy(busy_a[2])
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One full transaction; checks response latency and busy, returns rdata/err.
    task automatic access(input int inst, input logic rnw, input logic [15:0] a,
                          input logic [15:0] wd, input string tag,
                          output logic [15:0] rd, output logic e, output int acc_cyc);
        int waits;
        @(negedge clk);
        r_nw        = rnw;
        addr        = a;
        wdata       = wd;
        req_v[inst] = 1'b1;
        @(posedge clk);
        acc_cyc = cyc;
        @(negedge clk);
        waits = 0;
        while (!ready_a[inst] && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        chk({tag, " latency"}, 32'(waits), 32'(ws_of[inst]));
        chk({tag, " busy"}, {31'd0, busy_a[inst]}, 32'd1);
        rd          = rdata_a[inst];
        e           = err_a[inst];
        req_v[inst] = 1'b0;
    endtask

    initial begin
        logic [15:0] rd;
        logic        e;
        int          a0, a1, a2;
        logic [15:0] w0_exp;
        logic [15:0] w2_exp;
        logic        saw_ready;

        checks   = 0;
        passed   = 0;
        cyc      = 0;
        ws_of[0] = 1;
        ws_of[1] = 0;
        ws_of[2] = 3;
        req_v    = 3'b000;
        r_nw     = 1'b1;
        addr     = 16'h0000;
        wdata    = 16'h0000;

        // 1. reset then idle
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("in reset", {busy_a[0], ready_a[1], err_a[2], rdata_a[2]}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("idle %0d", i),
                {ready_a[0], err_a[0], busy_a[0], ready_a[1], err_a[1], busy_a[1],
                 ready_a[2], err_a[2], busy_a[2], 23'd0} | {16'd0, rdata_a[0] | rdata_a[1] | rdata_a[2]},
                32'd0);
        end

        // 2. write then read, one wait state
        access(0, 1'b0, 16'h0010, 16'hBEEF, "ws1 wr 0010", rd, e, a0);
        chk("ws1 wr 0010 err", {31'd0, e}, 32'd0);
        access(0, 1'b1, 16'h0010, 16'h0000, "ws1 rd 0010", rd, e, a0);
        chk("ws1 rd 0010 data", {16'd0, rd}, 32'h0000BEEF);
        chk("ws1 rd 0010 err", {31'd0, e}, 32'd0);
        access(0, 1'b1, 16'h0011, 16'h0000, "ws1 rd 0011", rd, e, a0);
        chk("ws1 rd 0011 data", {16'd0, rd}, 32'h0000BEEF);
        @(negedge clk);
        chk("ws1 ready one cycle", {31'd0, ready_a[0]}, 32'd0);
        chk("ws1 rdata holds", {16'd0, rdata_a[0]}, 32'h0000BEEF);

        // 3. zero wait states, back-to-back reads
        access(1, 1'b0, 16'h0010, 16'hBEEF, "ws0 wr 0010", rd, e, a0);
        access(1, 1'b1, 16'h0010, 16'h0000, "ws0 rd a", rd, e, a0);
        chk("ws0 rd a data", {16'd0, rd}, 32'h0000BEEF);
        access(1, 1'b1, 16'h0010, 16'h0000, "ws0 rd b", rd, e, a1);
        chk("ws0 rd b data", {16'd0, rd}, 32'h0000BEEF);
        access(1, 1'b1, 16'h0011, 16'h0000, "ws0 rd c", rd, e, a2);
        chk("ws0 rd c data", {16'd0, rd}, 32'h0000BEEF);
        chk("ws0 issue interval", 32'(a1 - a0), 32'd2);
        chk("ws0 three reads span", 32'(a2 - a0), 32'd4);

        // 4. out of range, word 0 and last word
`ifdef UBIO_MEM_WRITE_PROTECT_EN
        access(0, 1'b1, 16'h0000, 16'h0000, "ws1 rd word0 base", rd, e, a0);
        w0_exp = rd;
`else
        access(0, 1'b0, 16'h0000, 16'h0F0F, "ws1 wr word0", rd, e, a0);
        chk("ws1 wr word0 err", {31'd0, e}, 32'd0);
        w0_exp = 16'h0F0F;
`endif
        access(0, 1'b0, 16'h0200, 16'h1234, "oor wr", rd, e, a0);
        chk("oor wr err", {31'd0, e}, 32'd1);
        access(0, 1'b1, 16'h0200, 16'h0000, "oor rd", rd, e, a0);
        chk("oor rd data", {16'd0, rd}, 32'd0);
        chk("oor rd err", {31'd0, e}, 32'd1);
        access(0, 1'b1, 16'h0000, 16'h0000, "word0 rd", rd, e, a0);
        chk("word0 unchanged", {16'd0, rd}, {16'd0, w0_exp});
        chk("word0 rd err", {31'd0, e}, 32'd0);
        access(0, 1'b0, 16'h01FE, 16'hC0DE, "last wr", rd, e, a0);
        chk("last wr err", {31'd0, e}, 32'd0);
        access(0, 1'b1, 16'h01FF, 16'h0000, "last rd", rd, e, a0);
        chk("last rd data", {16'd0, rd}, 32'h0000C0DE);

        // 5. protect region boundary
`ifdef UBIO_MEM_WRITE_PROTECT_EN
        access(0, 1'b1, 16'h0004, 16'h0000, "ro base", rd, e, a0);
        w2_exp = rd;
        access(0, 1'b0, 16'h0004, 16'hAAAA, "ro wr", rd, e, a0);
        chk("ro wr err", {31'd0, e}, 32'd1);
`else
        w2_exp = 16'hAAAA;
        access(0, 1'b0, 16'h0004, 16'hAAAA, "ro wr", rd, e, a0);
        chk("ro wr err", {31'd0, e}, 32'd0);
`endif
        access(0, 1'b1, 16'h0004, 16'h0000, "ro rd", rd, e, a0);
        chk("ro rd data", {16'd0, rd}, {16'd0, w2_exp});
        access(0, 1'b0, 16'h0080, 16'h5A5A, "rw wr", rd, e, a0);
        chk("rw wr err", {31'd0, e}, 32'd0);
        access(0, 1'b1, 16'h0080, 16'h0000, "rw rd", rd, e, a0);
        chk("rw rd data", {16'd0, rd}, 32'h00005A5A);

        // 6. reset in the middle of a write, three wait states
        access(2, 1'b0, 16'h0080, 16'h1357, "ws3 wr old", rd, e, a0);
        chk("ws3 wr old err", {31'd0, e}, 32'd0);
        @(negedge clk);
        r_nw     = 1'b0;
        addr     = 16'h0080;
        wdata    = 16'h5555;
        req_v[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ws3 abort busy before rst", {31'd0, busy_a[2]}, 32'd1);
        chk("ws3 abort no early ready", {31'd0, ready_a[2]}, 32'd0);
        rst = 1'b1;
        #1;
        chk("ws3 abort busy cleared", {31'd0, busy_a[2]}, 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        req_v[2] = 1'b0;
        saw_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            saw_ready = saw_ready | ready_a[2];
        end
        chk("ws3 abort no ready", {31'd0, saw_ready}, 32'd0);
        access(2, 1'b1, 16'h0080, 16'h0000, "ws3 rd after abort", rd, e, a0);
        chk("ws3 old contents kept", {16'd0, rd}, 32'h00001357);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
